// File: rtl/sr_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sr_cond_pkg
// Purpose  : Shared constants for the SR latch input conditioner: channel
//            indices into the per-channel vectors and the default debounce
//            length.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sr_cond_pkg;

    // Channel positions inside the raw / debounced-state vectors
    localparam int CH_SET = 0;
    localparam int CH_RST = 1;
    localparam int CH_EN  = 2;
    localparam int NUM_CH = 3;

    // Default number of consecutive disagreeing clocks before a state flips
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage : sr_cond_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// Module   : debounce_channel
// Purpose  : One conditioning channel: 2-flop synchronizer followed by a
//            consecutive-sample debounce counter and the debounced state.
// Ports    : clk       - system clock, rising edge
//            reset     - synchronous, active-high reset
//            raw_in    - asynchronous, bouncy input
//            state_out - debounced level
// Revision : 1.0 - initial release
// ============================================================================
module debounce_channel
    import sr_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic state_out
);

    // Count value at which the next disagreeing sample flips the state
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1_q;
    logic             r_sync2_q;
    logic [CNT_W-1:0] r_cnt_q;
    logic             r_state_q;

    logic             w_sync1_d;
    logic             w_sync2_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_state_d;

    always_comb begin
        w_sync1_d = raw_in;
        w_sync2_d = r_sync1_q;
        w_cnt_d   = '0;
        w_state_d = r_state_q;
        if (r_sync2_q != r_state_q) begin
            if (r_cnt_q == c_cnt_last) begin
                // Enough consecutive disagreeing samples: accept new level
                w_state_d = r_sync2_q;
                w_cnt_d   = '0;
            end else begin
                w_cnt_d = r_cnt_q + CNT_W'(1);
            end
        end
        // Any agreeing sample leaves w_cnt_d at 0, restarting the count
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1_q <= 1'b0;
            r_sync2_q <= 1'b0;
            r_cnt_q   <= '0;
            r_state_q <= 1'b0;
        end else begin
            r_sync1_q <= w_sync1_d;
            r_sync2_q <= w_sync2_d;
            r_cnt_q   <= w_cnt_d;
            r_state_q <= w_state_d;
        end
    end

    assign state_out = r_state_q;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/sr_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : sr_button_conditioner
// Purpose  : Turns raw set/reset buttons and an enable switch into clean SR
//            latch controls: one-cycle s/r pulses that are never high
//            together, a debounced enable level, and a one-cycle flag for
//            any suppressed conflicting request.
// Ports    : clk       - system clock, rising edge
//            reset     - synchronous, active-high reset
//            btn_set   - raw set button (async, bouncy)
//            btn_reset - raw reset button (async, bouncy)
//            sw_enable - raw enable switch (async, bouncy)
//            s         - registered one-cycle set pulse
//            r         - registered one-cycle reset pulse
//            e         - debounced enable level
//            invalid   - registered one-cycle conflict flag
// Revision : 1.0 - initial release
// ============================================================================
module sr_button_conditioner
    import sr_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_set,
    input  logic btn_reset,
    input  logic sw_enable,
    output logic s,
    output logic r,
    output logic e,
    output logic invalid
);

    logic [NUM_CH-1:0] w_raw;
    logic [NUM_CH-1:0] w_state;

    assign w_raw[CH_SET] = btn_set;
    assign w_raw[CH_RST] = btn_reset;
    assign w_raw[CH_EN]  = sw_enable;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_debounce (
                .clk       (clk),
                .reset     (reset),
                .raw_in    (w_raw[gi]),
                .state_out (w_state[gi])
            );
        end
    endgenerate

    // Previous debounced state of set/reset channels for rising-edge detect.
    // Enable is passed straight through, so it needs no history.
    logic [CH_RST:CH_SET] r_prev_q;
    logic                 r_s_q;
    logic                 r_r_q;
    logic                 r_inv_q;

    logic [CH_RST:CH_SET] w_prev_d;
    logic                 w_s_d;
    logic                 w_r_d;
    logic                 w_inv_d;
    logic                 w_rise_set;
    logic                 w_rise_rst;

    always_comb begin
        w_prev_d   = w_state[CH_RST:CH_SET];
        w_rise_set = w_state[CH_SET] & ~r_prev_q[CH_SET];
        w_rise_rst = w_state[CH_RST] & ~r_prev_q[CH_RST];
        w_s_d      = w_rise_set;
        w_r_d      = w_rise_rst;
        w_inv_d    = 1'b0;

        if (w_rise_set && w_rise_rst) begin
            // Simultaneous requests: drop both
            w_s_d   = 1'b0;
            w_r_d   = 1'b0;
            w_inv_d = 1'b1;
        end else if (w_rise_set && w_state[CH_RST]) begin
            // Set requested while reset is still held down
            w_s_d   = 1'b0;
            w_inv_d = 1'b1;
        end else if (w_rise_rst && w_state[CH_SET]) begin
            // Reset requested while set is still held down
            w_r_d   = 1'b0;
            w_inv_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_q <= '0;
            r_s_q    <= 1'b0;
            r_r_q    <= 1'b0;
            r_inv_q  <= 1'b0;
        end else begin
            r_prev_q <= w_prev_d;
            r_s_q    <= w_s_d;
            r_r_q    <= w_r_d;
            r_inv_q  <= w_inv_d;
        end
    end

    assign s       = r_s_q;
    assign r       = r_r_q;
    assign e       = w_state[CH_EN];
    assign invalid = r_inv_q;

endmodule : sr_button_conditioner
`default_nettype wire

// File: tb/tb_sr_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_sr_button_conditioner
// Purpose  : Self-checking bench for sr_button_conditioner. Stimulus pushes
//            the expected pulse (cycle and kind) into a queue; a monitor on
//            the falling edge pops and compares whenever s, r or invalid is
//            high, and flags expected pulses whose cycle has passed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_button_conditioner;

    localparam int DB = 4;

    logic clk;
    logic reset;
    logic btn_set;
    logic btn_reset;
    logic sw_enable;
    logic s;
    logic r;
    logic e;
    logic invalid;

    sr_button_conditioner #(
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_set   (btn_set),
        .btn_reset (btn_reset),
        .sw_enable (sw_enable),
        .s         (s),
        .r         (r),
        .e         (e),
        .invalid   (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc == n during the low phase following rising edge n
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int   at;
        logic s;
        logic r;
        logic inv;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    // Expected pulse seen at the low phase after edge k + 3 + DB
    task automatic expect_pulse(input int k, input logic es, input logic er, input logic ei);
        exp_t x;
        x.at  = k + 3 + DB;
        x.s   = es;
        x.r   = er;
        x.inv = ei;
        exp_q.push_back(x);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: drops overdue expectations as misses, compares presented pulses
    always @(negedge clk) begin
        exp_t x;
        while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            x = exp_q.pop_front();
            check("missed_pulse_cycle", cyc, x.at);
        end
        if (s || r || invalid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse_sri", {29'd0, s, r, invalid}, 0);
            end else begin
                x = exp_q.pop_front();
                check("pulse_cycle", cyc, x.at);
                check("pulse_sri", {29'd0, s, r, invalid}, {29'd0, x.s, x.r, x.inv});
            end
        end
    end

    initial begin
        int k;
        reset     = 1'b1;
        btn_set   = 1'b1;
        btn_reset = 1'b0;
        sw_enable = 1'b0;

        // 1: reset held 3 cycles with set pressed; then press seen as new
        repeat (3) begin
            @(negedge clk);
            check("rst_s", s, 0);
            check("rst_r", r, 0);
            check("rst_e", e, 0);
            check("rst_inv", invalid, 0);
        end
        reset = 1'b0;
        k = cyc;
        expect_pulse(k, 1, 0, 0);
        idle(12);
        btn_set = 1'b0;
        idle(10);

        // 2: clean press held 20 cycles -> single s pulse
        k = cyc;
        btn_set = 1'b1;
        expect_pulse(k, 1, 0, 0);
        idle(20);
        btn_set = 1'b0;
        idle(10);

        // 3: bounce 1,0,1,0,1 then hold -> one pulse from last rise
        btn_set = 1'b1; idle(1);
        btn_set = 1'b0; idle(1);
        btn_set = 1'b1; idle(1);
        btn_set = 1'b0; idle(1);
        k = cyc;
        btn_set = 1'b1;
        expect_pulse(k, 1, 0, 0);
        idle(15);
        btn_set = 1'b0;
        idle(10);

        // 4: simultaneous press -> invalid only
        k = cyc;
        btn_set   = 1'b1;
        btn_reset = 1'b1;
        expect_pulse(k, 0, 0, 1);
        idle(15);
        btn_set   = 1'b0;
        btn_reset = 1'b0;
        idle(10);

        // 5: set held, then reset pressed -> s, then invalid
        k = cyc;
        btn_set = 1'b1;
        expect_pulse(k, 1, 0, 0);
        idle(10);
        k = cyc;
        btn_reset = 1'b1;
        expect_pulse(k, 0, 0, 1);
        idle(12);
        btn_set   = 1'b0;
        btn_reset = 1'b0;
        idle(10);

        // 6a: enable level follows after 2+DB edges
        k = cyc;
        sw_enable = 1'b1;
        wait_until(k + 1 + DB);
        check("en_before", e, 0);
        wait_until(k + 2 + DB);
        check("en_after", e, 1);
        idle(3);
        check("en_held", e, 1);

        // 6b: reset at edge 4 of a set debounce -> no pulse, e cleared
        k = cyc;
        btn_set = 1'b1;
        wait_until(k + 3);
        reset     = 1'b1;
        btn_set   = 1'b0;
        sw_enable = 1'b0;
        wait_until(k + 4);
        check("midrst_e", e, 0);
        check("midrst_s", s, 0);
        reset = 1'b0;
        idle(12);
        check("post_midrst_e", e, 0);

        idle(5);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sr_button_conditioner
`default_nettype wire

// File: doc/sr_button_conditioner.md
Name: sr_button_conditioner

Overview:
Input-conditioning stage that sits directly upstream of the SR latch bank. It turns raw, bouncy push-button and switch inputs into clean latch controls: a one-cycle set pulse (s), a one-cycle reset pulse (r) and a stable enable level (e). It arbitrates so that s and r are never high in the same cycle, and flags any conflicting request on a separate output.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive clocks a synchronized input must differ from its debounced state before that state flips; legal range 1 to 255.
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, never overridden.

Ports:
clk  input  1  single system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
btn_set  input  1  raw set button; asynchronous and bouncy.
btn_reset  input  1  raw reset button; asynchronous and bouncy.
sw_enable  input  1  raw enable switch; asynchronous and bouncy.
s  output  1  registered one-cycle set pulse to the latch.
r  output  1  registered one-cycle reset pulse to the latch.
e  output  1  debounced enable level to the latch.
invalid  output  1  registered one-cycle flag for a suppressed conflicting request.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port reset. It is sampled only on the rising edge of clk.
- Reset: clears every flop, including sync stages, counters, debounced states and output registers. Outputs s=r=e=invalid=0 in the cycle after the reset edge. Reset has priority over all other activity.
- Each channel (set, reset, enable) has three parts:
  - a 2-flop synchronizer, q1 then q2;
  - a debounce counter: cleared whenever q2 equals the debounced state, otherwise incremented. When q2 differs and the counter equals DEBOUNCE_CYCLES-1, the state toggles and the counter clears at that same edge.
  - Any single-cycle agreement between q2 and the state restarts the count from 0.
- Latency, counting edges from a raw change set up before edge 1:
  - debounced state flips at edge 2+DEBOUNCE_CYCLES;
  - e equals the enable channel's debounced state, so e changes at edge 2+DEBOUNCE_CYCLES (edge 6 at default);
  - s, r and invalid are registered from edge detection, so they assert at edge 3+DEBOUNCE_CYCLES (edge 7 at default) for exactly one cycle.
- Edge detection: rise_set and rise_rst are true when the debounced state goes 0 to 1. Falling edges produce nothing.
- Arbitration, evaluated combinationally and then registered:
  - rise_set and rise_rst in the same cycle: s=0, r=0, invalid=1.
  - rise_set while the debounced reset state is 1: s=0, invalid=1. The symmetric case for rise_rst while set is held gives r=0, invalid=1.
  - Otherwise s=rise_set, r=rise_rst, invalid=0.
- Invariant: s and r are never 1 in the same cycle.
- A button held through reset release is seen as a new press. It produces a pulse at edge 3+DEBOUNCE_CYCLES after release.
- Holding a button produces exactly one pulse. A new pulse needs a debounced release followed by a debounced press.
- e is independent of s/r arbitration. The latch performs the gating by e.
- Reset asserted mid-debounce: the counter and state clear, and no pulse is emitted for that press.

Decomposition:
- Shared package sr_cond_pkg holds:
  - channel index constants CH_SET=0, CH_RST=1, CH_EN=2;
  - the default DEBOUNCE_CYCLES value.
- One sub-module, debounce_channel, instantiated three times:
  - parameters DEBOUNCE_CYCLES and CNT_W;
  - ports clk, reset, raw_in, state_out.
  - It contains the synchronizer, counter and debounced state.
- The top level holds the edge-detect registers, the arbitration logic and the output registers.

Test Plan:
1. Reset: reset=1 for 3 cycles with btn_set=1 -> s=r=e=invalid=0 throughout. After release, a single s pulse at edge 7.
2. Clean press: btn_set 0 to 1 held 20 cycles -> s=1 for one cycle at edge 7. r=0 and invalid=0 throughout, and no second pulse while held.
3. Bounce: btn_set toggles 1,0,1,0,1 on successive cycles, then holds 1 -> exactly one s pulse, 7 edges after the final 0 to 1 transition.
4. Simultaneous press: btn_set and btn_reset rise on the same edge -> s=0 and r=0 always, invalid=1 for one cycle at edge 7.
5. Conflict while held: btn_set held until s pulses, then btn_reset pressed -> r stays 0, invalid pulses once, 7 edges after the btn_reset rise.
6. Enable and mid-debounce reset:
   - sw_enable 0 to 1 -> e=1 from edge 6 on.
   - reset pulsed at edge 4 of a btn_set debounce -> no s pulse from that press, and e returns to 0.
